// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - shared constants, FSM state type and helpers for the peer-link frame decoder
package uart_frame_pkg;

  localparam logic [7:0] SYNC_BYTE      = 8'hA5;
  localparam logic [7:0] TYPE_KEEPER    = 8'h01;
  localparam logic [7:0] TYPE_HEARTBEAT = 8'h02;

  typedef enum logic [2:0] {
    WAIT_SYNC,
    GET_TYPE,
    GET_HI,
    GET_LO,
    GET_CHK
  } frame_state_t;

  // Keeper position coming off the wire may exceed the playfield; pin it to the limit.
  function automatic logic [11:0] clamp_pos(input logic [11:0] raw, input logic [11:0] limit);
    return (raw > limit) ? limit : raw;
  endfunction

endpackage

// File: rtl/link_watchdog.sv
// rtl/link_watchdog.sv - saturating cycle counter with synchronous clear and expiry flag
module link_watchdog #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIMIT_C = W'(LIMIT);

  logic [W-1:0] count;

  // Count enabled cycles since the last clear, holding at LIMIT once reached.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT_C)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LIMIT_C);

endmodule

// File: rtl/uart_frame_decoder.sv
// rtl/uart_frame_decoder.sv - parses 5-byte peer frames into keeper position and link-health status
module uart_frame_decoder
  import uart_frame_pkg::*;
#(
  parameter logic [11:0] KEEPER_MAX     = 12'd1023,
  parameter int unsigned BYTE_TIMEOUT   = 65_000,
  parameter int unsigned LINK_TIMEOUT   = 32_500_000,
  parameter int unsigned CONNECT_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [11:0] keeper_pos,
  output logic        keeper_pos_valid,
  output logic        connect_corrected,
  output logic        frame_err
);

  localparam int unsigned SW = (CONNECT_FRAMES < 2) ? 1 : $clog2(CONNECT_FRAMES + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(CONNECT_FRAMES);

  frame_state_t state, state_next;

  logic [7:0]    type_q, hi_q, lo_q;
  logic [SW-1:0] streak;
  logic [11:0]   payload;
  logic          byte_expired, link_expired;
  logic          byte_clear, byte_enable;
  logic          good_keeper, good_heartbeat, good_frame, bad_frame, abort;

  assign payload     = {hi_q[3:0], lo_q};
  assign good_frame  = good_keeper | good_heartbeat;
  assign byte_clear  = rx_valid | (state == WAIT_SYNC);
  assign byte_enable = (state != WAIT_SYNC);

  link_watchdog #(.LIMIT(BYTE_TIMEOUT)) u_byte_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (byte_clear),
    .enable  (byte_enable),
    .expired (byte_expired)
  );

  link_watchdog #(.LIMIT(LINK_TIMEOUT)) u_link_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (good_frame),
    .enable  (1'b1),
    .expired (link_expired)
  );

  // Frame FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= WAIT_SYNC;
    end else begin
      state <= state_next;
    end
  end

  // Next state plus frame verdicts; a byte arriving always beats a byte-timer abort.
  always_comb begin
    state_next     = state;
    good_keeper    = 1'b0;
    good_heartbeat = 1'b0;
    bad_frame      = 1'b0;
    abort          = 1'b0;
    if (rx_valid) begin
      case (state)
        WAIT_SYNC: if (rx_data == SYNC_BYTE) state_next = GET_TYPE;
        GET_TYPE:  state_next = GET_HI;
        GET_HI:    state_next = GET_LO;
        GET_LO:    state_next = GET_CHK;
        GET_CHK: begin
          state_next = WAIT_SYNC;
          if (rx_data != (type_q ^ hi_q ^ lo_q)) begin
            bad_frame = 1'b1;
          end else if (type_q == TYPE_KEEPER) begin
            if (hi_q[7:4] != 4'h0) bad_frame = 1'b1;
            else                   good_keeper = 1'b1;
          end else if (type_q == TYPE_HEARTBEAT) begin
            good_heartbeat = 1'b1;
          end else begin
            bad_frame = 1'b1;
          end
        end
        default: state_next = WAIT_SYNC;
      endcase
    end else if (byte_expired && (state != WAIT_SYNC)) begin
      abort      = 1'b1;
      state_next = WAIT_SYNC;
    end
  end

  // Capture frame fields as they arrive so CHK can be judged in its own cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      type_q <= 8'h00;
      hi_q   <= 8'h00;
      lo_q   <= 8'h00;
    end else if (rx_valid) begin
      if (state == GET_TYPE) type_q <= rx_data;
      if (state == GET_HI)   hi_q   <= rx_data;
      if (state == GET_LO)   lo_q   <= rx_data;
    end
  end

  // Register verdicts into game-facing outputs, streak counter and link state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      keeper_pos        <= 12'd0;
      keeper_pos_valid  <= 1'b0;
      frame_err         <= 1'b0;
      streak            <= '0;
      connect_corrected <= 1'b0;
    end else begin
      keeper_pos_valid <= good_keeper;
      frame_err        <= bad_frame | abort;
      if (good_keeper) begin
        keeper_pos <= clamp_pos(payload, KEEPER_MAX);
      end
      if (good_frame) begin
        if (streak != STREAK_MAX) streak <= streak + 1'b1;
      end else if (bad_frame || abort || link_expired) begin
        streak <= '0;
      end
      if (link_expired && !good_frame) begin
        connect_corrected <= 1'b0;
      end else if (streak == STREAK_MAX) begin
        connect_corrected <= 1'b1;
      end
    end
  end

endmodule

// File: doc/uart_frame_decoder.md
Name: uart_frame_decoder

Overview:
- Upstream of game_state_sel: turns the byte stream from the board-to-board UART receiver into game inputs for multiplayer mode.
- Game inputs produced: keeper position from the peer board, plus a link-health flag (connect_corrected).
- Parses fixed 5-byte frames, checks an XOR checksum and runs a link watchdog, so game_state_sel only sees validated, clamped data.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- KEEPER_MAX, 12'd1023, upper clamp for decoded keeper position.
- BYTE_TIMEOUT, 65_000, max clk cycles between bytes inside one frame (1 ms @ 65 MHz).
- LINK_TIMEOUT, 32_500_000, clk cycles without a good frame before the link is declared lost (0.5 s).
- CONNECT_FRAMES, 2, consecutive good frames needed to raise connect_corrected.

Ports:
- clk  in  1  system clock (65 MHz pixel clock domain).
- rst  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte from UART RX core.
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle.
- keeper_pos  out  12  last accepted keeper position.
- keeper_pos_valid  out  1  one-cycle pulse when keeper_pos updates.
- connect_corrected  out  1  level: peer link established and alive.
- frame_err  out  1  one-cycle pulse on any rejected or aborted frame.

Behaviour:
- Reset (rst low, async): keeper_pos=0, keeper_pos_valid=0, connect_corrected=0, frame_err=0, FSM=WAIT_SYNC, all counters 0.
- Frame format: SYNC, TYPE, HI, LO, CHK, where CHK = TYPE ^ HI ^ LO.
- TYPE 8'h01 = keeper position; payload = {HI[3:0], LO}; HI[7:4] must be 0.
- TYPE 8'h02 = heartbeat; payload ignored.
- FSM advances only on rx_valid: WAIT_SYNC -> TYPE -> HI -> LO -> CHK -> WAIT_SYNC.
- In WAIT_SYNC, non-SYNC bytes are dropped silently with no frame_err.
- After SYNC, an 8'hA5 byte is ordinary data; there is no mid-frame resync.
- Byte timer: cleared on each rx_valid, counts while FSM != WAIT_SYNC. Reaching BYTE_TIMEOUT: FSM -> WAIT_SYNC, frame_err pulses, good-frame streak cleared.
- CHK evaluation happens on the cycle the CHK byte arrives (cycle n). Results registered and visible at n+1:
  - checksum mismatch, unknown TYPE, or HI[7:4]!=0 -> frame_err=1, streak=0, keeper_pos unchanged.
  - good TYPE 01 -> keeper_pos = min(payload, KEEPER_MAX), keeper_pos_valid=1, streak++, watchdog cleared.
  - good TYPE 02 -> streak++, watchdog cleared; keeper_pos_valid stays 0.
- Streak counter saturates at CONNECT_FRAMES. connect_corrected rises on the cycle after streak reaches CONNECT_FRAMES.
- Watchdog: counts every cycle and saturates. Reaching LINK_TIMEOUT: connect_corrected=0, streak=0. keeper_pos holds its last value.
- A good frame completing in the same cycle as watchdog expiry wins: counter cleared, link state not dropped.
- A bad frame does not drop connect_corrected; only the watchdog does.
- rx_valid on consecutive cycles must be accepted back-to-back with no lost bytes.
- Reset asserted mid-frame: partial frame discarded, all outputs return to reset values immediately.

Decomposition:
- uart_frame_pkg holds:
  - localparams SYNC_BYTE, TYPE_KEEPER=8'h01, TYPE_HEARTBEAT=8'h02.
  - typedef enum logic [2:0] {WAIT_SYNC, GET_TYPE, GET_HI, GET_LO, GET_CHK} frame_state_t.
- Sub-module link_watchdog: saturating counter with clear input, parameter LIMIT, output expired. Instantiated twice, once for the byte timer and once for the link timer.

Test Plan:
- Good keeper frame: A5 01 02 58 5B, then A5 01 02 58 5B again -> keeper_pos=12'h258 (600); one keeper_pos_valid pulse per frame, each one cycle after the CHK byte; connect_corrected=1 after the 2nd frame.
- Out-of-range clamp: A5 01 0F FF F1 -> keeper_pos=1023, keeper_pos_valid pulses, frame_err=0.
- Rejected frames with link up:
  - bad checksum A5 01 01 00 FF -> frame_err pulse, keeper_pos unchanged.
  - unknown type A5 07 00 00 07 -> frame_err pulse.
  - connect_corrected stays 1 in both cases.
- Byte timeout: A5 01 02, then BYTE_TIMEOUT cycles of silence -> one frame_err pulse. A following good frame A5 01 00 64 65 is still accepted: keeper_pos=100.
- Link loss: link up, then LINK_TIMEOUT cycles with only garbage bytes (no A5) -> connect_corrected=0 and keeper_pos held. Two heartbeats A5 02 00 00 02 -> link back up.
- Async reset mid-frame: drive rst low after A5 01 -> all outputs 0 on that edge. After release, the trailing bytes 02 58 5B are ignored (no A5 seen), with no pulses.
